// File: rtl/fetch_unit.sv
// Fetch unit: single-outstanding imem requester feeding a 2-entry {pc,instr} queue; head valid 2 cycles after request.
// Backpressure: stall_F holds the head, and a full queue stops requests; branch_taken flushes and redirects.
module fetch_unit #(
    parameter logic [10:0] RESET_PC = 11'h000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_F,
    input  logic        branch_taken,
    input  logic [10:0] branch_target,
    output logic        imem_req,
    output logic [10:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] instruction_out,
    output logic [10:0] pc_out,
    output logic        valid_out
);
    localparam logic [1:0] QD = QDEPTH[1:0];

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    state_t      state_q, state_d;
    logic [10:0] fetch_pc_q, fetch_pc_d;
    logic [10:0] req_pc_q, req_pc_d;
    logic [1:0]  count_q, count_d;
    logic [10:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [15:0] head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
    logic        push, pop;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        count_d      = count_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;

        imem_req = !reset && (state_q == S_IDLE) && (count_q < QD) && !branch_taken;
        push     = (state_q == S_WAIT) && imem_valid && !branch_taken;
        pop      = (count_q != 2'd0) && !stall_F && !branch_taken;

        if (imem_req) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 11'd1;
            state_d    = S_WAIT;
        end

        // A redirect with no response yet must still swallow that response later.
        case (state_q)
            S_WAIT: begin
                if (branch_taken)    state_d = imem_valid ? S_IDLE : S_DISCARD;
                else if (imem_valid) state_d = S_IDLE;
            end
            S_DISCARD: begin
                if (imem_valid) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (branch_taken) begin
            fetch_pc_d = branch_target;
            count_d    = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_pc_d    = req_pc_q;
                        head_instr_d = imem_data;
                    end else begin
                        tail_pc_d    = req_pc_q;
                        tail_instr_d = imem_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_pc_d    = tail_pc_q;
                    head_instr_d = tail_instr_q;
                    count_d      = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_pc_d    = req_pc_q;
                        head_instr_d = imem_data;
                    end else begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        tail_pc_d    = req_pc_q;
                        tail_instr_d = imem_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= 11'h000;
            count_q      <= 2'd0;
            head_pc_q    <= 11'h000;
            head_instr_q <= 16'h0000;
            tail_pc_q    <= 11'h000;
            tail_instr_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

    assign imem_addr       = fetch_pc_q;
    assign valid_out       = (count_q != 2'd0);
    assign instruction_out = valid_out ? head_instr_q : 16'h0000;
    assign pc_out          = valid_out ? head_pc_q : 11'h000;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 11'h000, PC value loaded on reset.
REQ-002 Parameter: QDEPTH, 2, instruction queue entries (fixed at 2 for this revision).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall_F  input  1  downstream FD stage holding; head entry not consumed.
REQ-006 branch_taken  input  1  redirect request from Execute.
REQ-007 branch_target  input  11  redirect PC, valid with branch_taken.
REQ-008 imem_req  output  1  instruction memory read request, one cycle per request.
REQ-009 imem_addr  output  11  read address, valid with imem_req.
REQ-010 imem_valid  input  1  read data returned, latency >= 1 cycle after imem_req.
REQ-011 imem_data  input  16  instruction word, valid with imem_valid.
REQ-012 instruction_out  output  16  queue-head instruction to FD_Register instruction_in.
REQ-013 pc_out  output  11  queue-head PC to FD_Register pc_in.
REQ-014 valid_out  output  1  queue head holds a valid instruction.

Function
REQ-015 State: fetch_pc (11b), req_pc (11b), 2-entry queue of {pc,instr}, count (0..2), request FSM {IDLE, WAIT, DISCARD}.
REQ-016 At most one outstanding memory request.
REQ-017 imem_req = (state==IDLE) && (count<2) && !branch_taken, combinational; imem_addr = fetch_pc.
REQ-018 On imem_req: req_pc <= fetch_pc; fetch_pc <= fetch_pc+1 mod 2^11 (11'h7FF wraps to 11'h000); state -> WAIT.
REQ-019 WAIT with imem_valid and no redirect: push {req_pc, imem_data}; state -> IDLE.
REQ-020 Pop: when valid_out && !stall_F, head removed on that edge; push and pop in the same cycle allowed, count unchanged.
REQ-021 Count never exceeds 2; request gating in REQ-017 guarantees a push never hits a full queue.
REQ-022 valid_out = (count!=0); when count==0, instruction_out=16'h0000 (NOP) and pc_out=11'h000.
REQ-023 Outputs driven from queue storage registers only; no combinational path from imem_data to instruction_out.
REQ-024 Redirect (branch_taken=1), highest priority: queue cleared (count<=0), fetch_pc <= branch_target, no push, no pop, imem_req forced 0.
REQ-025 Redirect while WAIT without imem_valid: state -> DISCARD; redirect while WAIT with imem_valid, or in IDLE/DISCARD: state -> IDLE, or stays DISCARD if a discarded response is still pending.
REQ-026 DISCARD: on imem_valid, data dropped, state -> IDLE; a further redirect in DISCARD updates fetch_pc only.
REQ-027 Redirect overrides stall_F in the same cycle.
REQ-028 Minimum latency with 1-cycle memory: request cycle N, data cycle N+1, valid_out high from cycle N+2.
REQ-029 Steady state with 1-cycle memory and no stall: one instruction every 2 cycles (single outstanding request).

Reset
REQ-030 Asynchronous assert: fetch_pc=RESET_PC, req_pc=0, count=0, state=IDLE, valid_out=0, instruction_out=16'h0000, pc_out=11'h000, imem_req=0 while reset high.
REQ-031 Reset mid-request: any later imem_valid for the lost request arriving while state==IDLE is ignored.
REQ-032 First imem_req with imem_addr=RESET_PC in the first cycle after reset deasserts.

Verification
REQ-033 Reset release, 1-cycle memory returning 16'h1000+addr, stall_F=0 -> pc_out sequence 0,1,2,3 with instruction_out 16'h1000,16'h1001,... each valid_out pulse.
REQ-034 stall_F=1 held 10 cycles -> count reaches 2, imem_req low, head stays pc_out=0 and instruction_out=16'h1000; release -> pc 0,1,2 delivered in order, no loss.
REQ-035 branch_taken=1, branch_target=11'h200 while a request to 11'h005 is outstanding -> 11'h005 response dropped, next imem_addr=11'h200, next valid pc_out=11'h200.
REQ-036 branch_target=11'h7FE, no stall -> pc_out 11'h7FE, 11'h7FF, 11'h000 (wrap).
REQ-037 branch_taken and imem_valid in the same cycle with count=1 -> queue empty next cycle, returned data not pushed, valid_out=0.
REQ-038 Reset asserted with count=2 and state WAIT -> outputs zero immediately (asynchronous), imem_addr=RESET_PC after release.
